// File: rtl/sparse_encoder_if.sv
// sparse_encoder_if
// Pixel-in / entry-out stream bundle for sparse_encoder.
//   in_valid, pixel_in  : dense pixel stream from the producer
//   in_ready            : encoder can take a pixel this cycle
//   out_valid, out_*    : head entry of the encoder output FIFO
//   out_ready           : consumer takes the head entry this cycle
// Modports:
//   master : producer/consumer side (drives in_valid, pixel_in, out_ready)
//   slave  : encoder side
interface sparse_encoder_if #(
  parameter int word_length = 8,
  parameter int col_length  = 8
);
  logic                          in_valid;
  logic                          in_ready;
  logic signed [word_length-1:0] pixel_in;
  logic                          out_valid;
  logic                          out_ready;
  logic signed [word_length-1:0] out_value;
  logic [col_length-1:0]         out_col;
  logic [col_length-1:0]         out_row;
  logic                          out_last;

  modport master (
    output in_valid, pixel_in, out_ready,
    input  in_ready, out_valid, out_value, out_col, out_row, out_last
  );

  modport slave (
    input  in_valid, pixel_in, out_ready,
    output in_ready, out_valid, out_value, out_col, out_row, out_last
  );
endinterface

// File: rtl/sparse_encoder.sv
// sparse_encoder
// Converts a raster-order dense frame of signed pixels into a stream of
// {value, col, row} entries for the nonzero pixels. The entry stream of each
// frame is padded with zero entries to a multiple of 4 and its final entry
// carries out_last. A 4-deep FIFO decouples the two streams.
// Ports:
//   clk               : clock, rising edge
//   rst               : synchronous active-high reset
//   bus               : sparse_encoder_if.slave (pixel in / entry out streams)
//   frame_done        : one-cycle pulse once a frame has fully drained
//   feature_valid_num : nonzero count of the last completed frame
//   state_dbg         : current FSM state (SCAN=0, PAD=1, DRAIN=2)
//
// Handshake: a beat transfers on a rising edge where valid and ready are both
// 1. in_ready does not depend on in_valid, and out_valid does not depend on
// out_ready. Once asserted, out_valid and the head entry hold until popped.
module sparse_encoder #(
  parameter int word_length        = 8,
  parameter int col_length         = 8,
  parameter int double_word_length = 16,
  parameter int image_size         = 28
) (
  input  logic                          clk,
  input  logic                          rst,
  sparse_encoder_if.slave               bus,
  output logic                          frame_done,
  output logic [double_word_length-1:0] feature_valid_num,
  output logic [1:0]                    state_dbg
);

  typedef enum logic [1:0] {
    SCAN  = 2'd0,
    PAD   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [col_length-1:0] last_coord = col_length'(image_size - 1);

  state_t state, state_next;

  // Raster position and per-frame nonzero count
  logic [col_length-1:0]         col, row;
  logic [double_word_length-1:0] n_count;

  // One-entry staging register holding the most recent nonzero pixel
  logic                   staged_valid;
  logic [word_length-1:0] staged_value;
  logic [col_length-1:0]  staged_col, staged_row;

  // Pushes into the FIFO this frame, modulo 4 (drives padding and last)
  logic [1:0] push_cnt;

  // Output FIFO
  logic [word_length-1:0] fifo_value [4];
  logic [col_length-1:0]  fifo_col   [4];
  logic [col_length-1:0]  fifo_row   [4];
  logic                   fifo_last  [4];
  logic [1:0]             wr_ptr, rd_ptr;
  logic [2:0]             fifo_count;
  logic                   fifo_full, fifo_empty, fifo_space;

  logic                   in_ready_int;
  logic                   accept, nonzero, frame_end;
  logic                   pop, push;
  logic [word_length-1:0] push_value;
  logic [col_length-1:0]  push_col, push_row;
  logic                   push_last;
  logic                   staged_clear;
  logic                   done_now;

  assign fifo_full  = (fifo_count == 3'd4);
  assign fifo_empty = (fifo_count == 3'd0);
  assign pop        = !fifo_empty && bus.out_ready;
  // A simultaneous pop frees a slot, so a push on a full FIFO is legal then
  assign fifo_space = !fifo_full || pop;

  assign in_ready_int = (state == SCAN) && !fifo_full;
  assign accept       = bus.in_valid && in_ready_int;
  assign nonzero      = (bus.pixel_in != '0);
  assign frame_end    = accept && (col == last_coord) && (row == last_coord);

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = !fifo_empty;
  assign bus.out_value = fifo_empty ? '0   : fifo_value[rd_ptr];
  assign bus.out_col   = fifo_empty ? '0   : fifo_col[rd_ptr];
  assign bus.out_row   = fifo_empty ? '0   : fifo_row[rd_ptr];
  assign bus.out_last  = fifo_empty ? 1'b0 : fifo_last[rd_ptr];

  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) state <= SCAN;
    else     state <= state_next;
  end

  always_comb begin
    state_next   = state;
    push         = 1'b0;
    push_value   = staged_value;
    push_col     = staged_col;
    push_row     = staged_row;
    push_last    = 1'b0;
    staged_clear = 1'b0;
    done_now     = 1'b0;
    case (state)
      SCAN: begin
        // A new nonzero pixel displaces the staged one into the FIFO
        if (accept && nonzero && staged_valid) push = 1'b1;
        if (frame_end) begin
          if (n_count != '0 || nonzero) state_next = PAD;
          else                          state_next = DRAIN;
        end
      end
      PAD: begin
        if (fifo_space) begin
          push = 1'b1;
          if (staged_valid) begin
            staged_clear = 1'b1;
          end else begin
            push_value = '0;
            push_col   = '0;
            push_row   = '0;
          end
          // The push that completes a group of 4 ends the frame
          if (push_cnt == 2'd3) begin
            push_last  = 1'b1;
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (fifo_empty) begin
          done_now   = 1'b1;
          state_next = SCAN;
        end
      end
      default: state_next = SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col               <= '0;
      row               <= '0;
      n_count           <= '0;
      staged_valid      <= 1'b0;
      staged_value      <= '0;
      staged_col        <= '0;
      staged_row        <= '0;
      push_cnt          <= '0;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      fifo_count        <= '0;
      frame_done        <= 1'b0;
      feature_valid_num <= '0;
      for (int i = 0; i < 4; i++) begin
        fifo_value[i] <= '0;
        fifo_col[i]   <= '0;
        fifo_row[i]   <= '0;
        fifo_last[i]  <= 1'b0;
      end
    end else begin
      if (accept) begin
        if (col == last_coord) begin
          col <= '0;
          row <= (row == last_coord) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        if (nonzero) begin
          n_count      <= n_count + 1'b1;
          staged_valid <= 1'b1;
          staged_value <= bus.pixel_in;
          staged_col   <= col;
          staged_row   <= row;
        end
      end

      if (staged_clear) staged_valid <= 1'b0;

      if (push) begin
        fifo_value[wr_ptr] <= push_value;
        fifo_col[wr_ptr]   <= push_col;
        fifo_row[wr_ptr]   <= push_row;
        fifo_last[wr_ptr]  <= push_last;
        wr_ptr             <= wr_ptr + 1'b1;
        push_cnt           <= push_cnt + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= fifo_count + 3'(push) - 3'(pop);

      frame_done <= done_now;
      if (done_now) begin
        feature_valid_num <= n_count;
        n_count           <= '0;
        staged_valid      <= 1'b0;
        staged_value      <= '0;
        staged_col        <= '0;
        staged_row        <= '0;
        push_cnt          <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sparse_encoder.sv
// tb_sparse_encoder
// Randomized self-checking bench for sparse_encoder. A frame-level model
// (list of nonzero pixels in raster order plus zero padding) fills an
// expected queue; a monitor pops and compares every transferred entry and
// the feature_valid_num reported with each frame_done pulse.
module tb_sparse_encoder;

  localparam int img  = 28;
  localparam int npix = img * img;
  localparam int w    = 25;  // {last, value[7:0], col[7:0], row[7:0]}

  logic        clk;
  logic        rst;
  logic        frame_done;
  logic [15:0] feature_valid_num;
  logic [1:0]  state_dbg;

  sparse_encoder_if #(.word_length(8), .col_length(8)) bus ();

  sparse_encoder #(
    .word_length(8),
    .col_length(8),
    .double_word_length(16),
    .image_size(img)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .frame_done(frame_done),
    .feature_valid_num(feature_valid_num),
    .state_dbg(state_dbg)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_seen = 0;
  int frames_expected = 0;
  int ready_pct = 100;
  int stall_until = 0;

  logic [w-1:0] exp_q[$];
  int           exp_n_q[$];
  logic [7:0]   frame[npix];

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic build_expected();
    int n;
    logic [w-1:0] e;
    n = 0;
    for (int p = 0; p < npix; p++) begin
      if (frame[p] != 8'd0) begin
        exp_q.push_back({1'b0, frame[p], 8'(p % img), 8'(p / img)});
        n++;
      end
    end
    if (n > 0) begin
      for (int k = 0; k < (4 - n % 4) % 4; k++) exp_q.push_back('0);
      e = exp_q.pop_back();
      e[w-1] = 1'b1;
      exp_q.push_back(e);
    end
    exp_n_q.push_back(n);
    frames_expected++;
  endtask

  task automatic gen_frame(input int density_pct);
    for (int p = 0; p < npix; p++)
      frame[p] = ($urandom_range(99, 0) < density_pct) ? 8'($urandom_range(255, 1)) : 8'd0;
  endtask

  // ---------------- drivers ----------------
  // Called at posedge+1; returns at posedge+1 after the pixel is accepted.
  task automatic drive_pixel(input logic [7:0] px, input int gap_pct);
    int budget;
    while ($urandom_range(99, 0) < gap_pct) begin
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b1;
    bus.pixel_in = px;
    budget = 0;
    @(negedge clk);
    while (!bus.in_ready && budget < 5000) begin
      budget++;
      @(negedge clk);
    end
    if (budget >= 5000) check_eq("in_ready_timeout", budget, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic drive_range(input int from, input int to, input int gap_pct);
    for (int p = from; p < to; p++) drive_pixel(frame[p], gap_pct);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int budget;
    budget = 0;
    while (done_seen < frames_expected && budget < 20000) begin
      budget++;
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    check_eq("frames_done", done_seen, frames_expected);
    check_eq("exp_q_drained", exp_q.size(), 0);
    check_eq("exp_n_drained", exp_n_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state();
    @(negedge clk);
    check_eq("rst_out_valid", bus.out_valid, 0);
    check_eq("rst_out_last", bus.out_last, 0);
    check_eq("rst_frame_done", frame_done, 0);
    check_eq("rst_fvn", feature_valid_num, 0);
    check_eq("rst_in_ready", bus.in_ready, 1);
    check_eq("rst_out_data", {bus.out_value, bus.out_col, bus.out_row}, 0);
    @(posedge clk);
    #1;
  endtask

  // out_ready: held low until stall_until, then random at ready_pct
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = (cyc >= stall_until) && ($urandom_range(99, 0) < ready_pct);
    end
  end

  // ---------------- scoreboard / monitor ----------------
  initial begin
    logic [31:0] got;
    logic [31:0] exp;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid && bus.out_ready) begin
        got = 32'({bus.out_last, bus.out_value, bus.out_col, bus.out_row});
        if (exp_q.size() > 0) exp = 32'(exp_q.pop_front());
        else                  exp = 32'hFFFF_FFFF;
        check_eq("entry", got, exp);
      end
      if (!rst && frame_done) begin
        done_seen++;
        if (exp_n_q.size() > 0) exp = 32'(exp_n_q.pop_front());
        else                    exp = 32'hFFFF_FFFF;
        check_eq("feature_valid_num", feature_valid_num, exp);
      end
    end
  end

  // Hard bound on total run time
  initial begin
    #(900_000);
    check_eq("watchdog_expired", cyc, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    int done_before;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.pixel_in = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_state();

    // All-zero frame: no entries, one frame_done, count 0
    ready_pct = 100;
    for (int p = 0; p < npix; p++) frame[p] = 8'd0;
    build_expected();
    drive_range(0, npix, 0);
    wait_done();

    // Three scattered nonzero pixels: one pad entry
    for (int p = 0; p < npix; p++) frame[p] = 8'd0;
    frame[0]          = 8'd5;
    frame[3 * img + 2] = 8'd7;
    frame[npix - 1]   = 8'hFF;
    build_expected();
    drive_range(0, npix, 10);
    wait_done();

    // Exactly four nonzero pixels at positions 0..3: no padding
    for (int p = 0; p < npix; p++) frame[p] = (p < 4) ? 8'($urandom_range(255, 1)) : 8'd0;
    build_expected();
    drive_range(0, npix, 0);
    wait_done();

    // Dense frame with the consumer stalled for 20 cycles
    for (int p = 0; p < npix; p++) frame[p] = 8'($urandom_range(255, 1));
    stall_until = cyc + 20;
    build_expected();
    drive_range(0, 5, 0);
    @(negedge clk);
    check_eq("dense_in_ready_after5", bus.in_ready, 0);
    repeat (3) @(negedge clk);
    check_eq("dense_in_ready_held", bus.in_ready, 0);
    @(posedge clk);
    #1;
    drive_range(5, npix, 0);
    wait_done();

    // Reset in the middle of a frame: partial frame abandoned
    ready_pct = 70;
    gen_frame(50);
    for (int p = 0; p < 100; p++)
      if (frame[p] != 8'd0) exp_q.push_back({1'b0, frame[p], 8'(p % img), 8'(p / img)});
    done_before = done_seen;
    drive_range(0, 100, 20);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    check_reset_state();
    check_eq("no_done_on_abort", done_seen, done_before);

    // Fresh frame after reset: single 9 at (row 1, col 1)
    ready_pct = 100;
    for (int p = 0; p < npix; p++) frame[p] = 8'd0;
    frame[img + 1] = 8'd9;
    build_expected();
    drive_range(0, npix, 0);
    wait_done();

    // Three back-to-back random frames with stalls on both streams
    ready_pct = 60;
    for (int f = 0; f < 3; f++) begin
      gen_frame(20 + 20 * f);
      build_expected();
      drive_range(0, npix, 30);
    end
    wait_done();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
